// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants
// for the mode-0 SPI slave controller
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser plus
// history flop giving rise/fall events
module spi_pin_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // shift the pin through the chain, remember last synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{IDLE_LVL}};
      hist <= IDLE_LVL;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: mode-0 SPI slave, clk-domain
// frame FSM, MSB-first shifting, TX buffer, RX strobe
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_buf;
  logic              buf_full;
  logic              word_done;
  logic              rx_pend;
  logic              load_now;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_pin_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (SCLK_IDLE)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_pin_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (CS_IDLE)
  ) u_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_LVL (MOSI_IDLE)
  ) u_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  wire unused_ok = &{1'b0, sclk_lvl, cs_lvl,
                     mosi_rise, mosi_fall};

  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_s};
  assign tx_ready = ~buf_full;
  assign busy     = (state != IDLE);

  // a word is loaded at frame start or on the fall after a full word
  assign load_now = (state == LOAD) |
                    ((state == SHIFT) & ~cs_rise &
                     sclk_fall & word_done);

  // frame FSM, shift registers, TX buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      tx_buf    <= '0;
      buf_full  <= 1'b0;
      word_done <= 1'b0;
      rx_pend   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      rx_valid  <= rx_pend;
      rx_pend   <= 1'b0;
      frame_err <= 1'b0;
      underrun  <= load_now & ~buf_full;

      if (tx_valid & ~buf_full) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end else if (load_now) begin
        buf_full <= 1'b0;
      end

      if (load_now) begin
        tx_sr <= buf_full ? tx_buf : '0;
        miso  <= buf_full & tx_buf[DATA_W-1];
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          cnt       <= '0;
          word_done <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_err <= (cnt != '0);
            state     <= IDLE;
            rx_sr     <= '0;
            cnt       <= '0;
            word_done <= 1'b0;
            miso      <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_sr <= rx_next;
              if (cnt == CW'(DATA_W - 1)) begin
                rx_data   <= rx_next;
                rx_pend   <= 1'b1;
                cnt       <= '0;
                word_done <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            if (sclk_fall) begin
              if (word_done) begin
                word_done <= 1'b0;
              end else begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                miso  <= tx_sr[DATA_W-2];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Mode-0 SPI slave controller; sequences the whole serial transfer in the system clock domain.
- Synchronises sclk, cs_n and mosi, then detects their edges.
- Runs the frame state machine and bit counter, and shifts MSB-first data in and out.
- Exchanges parallel words with the core through a one-entry TX buffer (valid/ready) and a one-cycle RX strobe.

Parameters:
DATA_W, 8, word width in bits (≥2).
SYNC_STAGES, 2, synchroniser flops on each SPI pin (≥2).

Ports:
clk  in  1  system clock; must be ≥8× sclk frequency.
rst_n  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock from master, asynchronous, idle low.
cs_n  in  1  SPI chip select, active low, asynchronous.
mosi  in  1  serial data from master, asynchronous.
miso  out  1  serial data to master.
tx_data  in  DATA_W  word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  TX buffer empty, write accepted.
rx_data  out  DATA_W  last received word, held until the next word completes.
rx_valid  out  1  one-cycle strobe: rx_data updated.
busy  out  1  frame in progress (state ≠ IDLE).
underrun  out  1  one-cycle pulse: word loaded while TX buffer empty.
frame_err  out  1  one-cycle pulse: cs_n rose mid-word.

Behaviour:
- Reset, asynchronous: all of the following clear.
  - Outputs: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0.
  - Internal: synchroniser flops set to idle levels (sclk 0, cs_n 1, mosi 0); FSM=IDLE; bit count=0; shift regs=0; TX buffer empty.
  - Reset mid-frame abandons the frame silently, with no frame_err.
- Input sync: each pin passes through SYNC_STAGES flops, then one edge-history flop.
  - sclk_rise/sclk_fall/cs_fall/cs_rise = synced value vs history.
  - Event fires SYNC_STAGES to SYNC_STAGES+1 clk cycles after the pin edge.
  - mosi is sampled from its synchronised copy on the sclk_rise cycle; the sclk and mosi pipelines have equal depth.
- TX buffer:
  - Written when tx_valid & tx_ready; tx_ready deasserts the next cycle.
  - tx_ready reasserts the cycle after the buffer is consumed by a load.
  - No bypass: a write in the same cycle as a load lands in the buffer for the next word.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: on cs_fall → LOAD.
  - LOAD, one cycle:
    - tx shift reg ← buffer if full and mark buffer empty; otherwise tx shift reg ← 0 and pulse underrun.
    - bit count=0; → SHIFT.
  - SHIFT, on sclk_rise:
    - rx shift reg ← {rx_sr[DATA_W-2:0], mosi_s}; count++.
    - On the DATA_W-th rise: rx_data ← the new value, rx_valid=1 next cycle, count=0, set word_done.
  - SHIFT, on sclk_fall:
    - If word_done: reload the tx shift reg as in LOAD (buffer or 0 + underrun); clear word_done.
    - Else: shift tx reg left by one, 0 in.
  - SHIFT, on cs_rise:
    - frame_err pulses if count≠0, else no pulse.
    - → IDLE; rx shift reg and count cleared.
    - A partial word is discarded; rx_data is unchanged.
- miso = tx_sr[DATA_W-1] while state≠IDLE, else 0. Registered: it changes on the cycle after LOAD or the falling-edge shift.
- Simultaneous events:
  - cs_rise beats sclk events in the same cycle; the sclk event is ignored.
  - cs_fall in LOAD/SHIFT cannot occur; ignored.
- Master requirement, not checked: first sclk rise ≥ SYNC_STAGES+3 clk cycles after cs_n falls.
- Width rules: bit count is $clog2(DATA_W+1) bits; no wrap beyond DATA_W.

Decomposition:
- Package spi_pkg:
  - FSM state enum (IDLE/LOAD/SHIFT).
  - Default DATA_W/SYNC_STAGES constants.
  - Idle-level constants for sclk/cs_n/mosi.
- One sub-module: spi_pin_sync, instantiated 3×. It holds the parameterised synchroniser plus history flop with rise/fall outputs, reset to a parameterised idle level.
- FSM, counters and buffers stay in spi_slave_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-frame, with 3 bits shifted → all outputs at reset values immediately; after release busy=0, tx_ready=1, no frame_err.
- Single word: write tx 0xA5, master sends 0x3C, clk=8× sclk → miso bits 1,0,1,0,0,1,0,1 sampled on sclk rises; rx_data=0x3C; exactly one rx_valid, 3-4 clk after the 8th sclk rise; tx_ready back to 1.
- Two-word frame: 0x12 preloaded, 0x34 written after the first LOAD; master sends 0xF0,0x0F → miso 0x12 then 0x34; rx_valid twice with 0xF0 then 0x0F; no underrun.
- Underrun: no tx write, one-word frame → underrun one pulse at LOAD, miso=0 all bits, rx still captured correctly.
- Abort: cs_n high after 5 sclk rises → frame_err one pulse, no rx_valid, rx_data unchanged; next full frame 0x81 received correctly.
- Simultaneous: sclk rise coincident with cs_n rise (same synced cycle) → no bit counted, frame_err per count, FSM=IDLE.
